// File: rtl/bus_rd_arbiter.sv
// Round-robin arbiter sharing one bus read channel (AR + R) among NUM_REQ requesters.
// state  | meaning
// IDLE   | no burst owned; pick the next requester round-robin from ptr+1
// ADDR   | drive captured address phase until the bus accepts it
// DATA   | route beats whose rid matches the captured id back to the grantee
module bus_rd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 28,
  parameter int LEN_W   = 4,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         ReqArb_arvalid,
  input  logic [NUM_REQ*ADDR_W-1:0]  ReqArb_araddr,
  input  logic [NUM_REQ*LEN_W-1:0]   ReqArb_arlen,
  input  logic [NUM_REQ*ID_W-1:0]    ReqArb_aruserid,
  input  logic [NUM_REQ-1:0]         ReqArb_aruserap,
  output logic [NUM_REQ-1:0]         ArbReq_arready,
  output logic [NUM_REQ-1:0]         ArbReq_rvalid,
  output logic [NUM_REQ-1:0]         ArbReq_rlast,
  output logic [DATA_W-1:0]          ArbReq_rdata,
  output logic                       ArbBus_arvalid,
  output logic [ADDR_W-1:0]          ArbBus_araddr,
  output logic [LEN_W-1:0]           ArbBus_arlen,
  output logic [ID_W-1:0]            ArbBus_aruserid,
  output logic                       ArbBus_aruserap,
  input  logic                       BusArb_arready,
  input  logic                       BusArb_rvalid,
  input  logic                       BusArb_rlast,
  input  logic [ID_W-1:0]            BusArb_rid,
  input  logic [DATA_W-1:0]          BusArb_rdata,
  output logic                       arb_busy,
  output logic [$clog2(NUM_REQ)-1:0] arb_grant,
  output logic                       arb_err_len
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [NUM_REQ-1:0]   arready_q, arready_d;
  logic                 arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 ap_q, ap_d;
  logic [LEN_W:0]       cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 pick_vld;
  logic [GW-1:0]        pick_idx;
  logic [GW-1:0]        cand;
  logic                 match;
  logic [LEN_W:0]       cnt_inc;
  logic [LEN_W:0]       beats_exp;

  // Search ptr+1, ptr+2, ... with wrap; first asserted request wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == GW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!pick_vld && ReqArb_arvalid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign match     = (state_q == S_DATA) && BusArb_rvalid && (BusArb_rid == id_q);
  assign cnt_inc   = cnt_q + 1'b1;
  assign beats_exp = {1'b0, len_q} + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    arready_d = '0;
    arvalid_d = 1'b0;
    addr_d    = addr_q;
    len_d     = len_q;
    id_d      = id_q;
    ap_d      = ap_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d             = pick_idx;
          arready_d[pick_idx] = 1'b1;
          arvalid_d           = 1'b1;
          addr_d              = ReqArb_araddr[pick_idx*ADDR_W +: ADDR_W];
          len_d               = ReqArb_arlen[pick_idx*LEN_W +: LEN_W];
          id_d                = ReqArb_aruserid[pick_idx*ID_W +: ID_W];
          ap_d                = ReqArb_aruserap[pick_idx];
          state_d             = S_ADDR;
        end
      end
      S_ADDR: begin
        if (BusArb_arready) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      S_DATA: begin
        if (match) begin
          cnt_d = cnt_inc;
          if (BusArb_rlast) begin
            if (cnt_inc != beats_exp) err_d = 1'b1;
            ptr_d   = grant_q;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= GW'(NUM_REQ - 1);
      grant_q   <= '0;
      arready_q <= '0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      ap_q      <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      arready_q <= arready_d;
      arvalid_q <= arvalid_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
      ap_q      <= ap_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Beats reach the grantee with zero latency; rdata is a plain pass-through.
  always_comb begin
    ArbReq_rvalid = '0;
    ArbReq_rlast  = '0;
    if (match) begin
      ArbReq_rvalid[grant_q] = 1'b1;
      ArbReq_rlast[grant_q]  = BusArb_rlast;
    end
  end

  assign ArbReq_rdata    = BusArb_rdata;
  assign ArbReq_arready  = arready_q;
  assign ArbBus_arvalid  = arvalid_q;
  assign ArbBus_araddr   = addr_q;
  assign ArbBus_arlen    = len_q;
  assign ArbBus_aruserid = id_q;
  assign ArbBus_aruserap = ap_q;
  assign arb_busy        = (state_q != S_IDLE);
  assign arb_grant       = grant_q;
  assign arb_err_len     = err_q;

endmodule

// File: tb/tb_bus_rd_arbiter.sv
// Bench for bus_rd_arbiter: vector table of bursts with hand-derived grants,
// queue scoreboards for address handshakes and returned beats, plus a reset-mid-burst sequence.
module tb_bus_rd_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 4;
  localparam int ADDR_W  = 28;
  localparam int LEN_W   = 4;
  localparam int DATA_W  = 32;
  localparam int GW      = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        ReqArb_arvalid;
  logic [NUM_REQ*ADDR_W-1:0] ReqArb_araddr;
  logic [NUM_REQ*LEN_W-1:0]  ReqArb_arlen;
  logic [NUM_REQ*ID_W-1:0]   ReqArb_aruserid;
  logic [NUM_REQ-1:0]        ReqArb_aruserap;
  logic [NUM_REQ-1:0]        ArbReq_arready;
  logic [NUM_REQ-1:0]        ArbReq_rvalid;
  logic [NUM_REQ-1:0]        ArbReq_rlast;
  logic [DATA_W-1:0]         ArbReq_rdata;
  logic                      ArbBus_arvalid;
  logic [ADDR_W-1:0]         ArbBus_araddr;
  logic [LEN_W-1:0]          ArbBus_arlen;
  logic [ID_W-1:0]           ArbBus_aruserid;
  logic                      ArbBus_aruserap;
  logic                      BusArb_arready;
  logic                      BusArb_rvalid;
  logic                      BusArb_rlast;
  logic [ID_W-1:0]           BusArb_rid;
  logic [DATA_W-1:0]         BusArb_rdata;
  logic                      arb_busy;
  logic [GW-1:0]             arb_grant;
  logic                      arb_err_len;

  always #5 clk = ~clk;

  bus_rd_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ReqArb_arvalid(ReqArb_arvalid), .ReqArb_araddr(ReqArb_araddr), .ReqArb_arlen(ReqArb_arlen),
    .ReqArb_aruserid(ReqArb_aruserid), .ReqArb_aruserap(ReqArb_aruserap),
    .ArbReq_arready(ArbReq_arready), .ArbReq_rvalid(ArbReq_rvalid), .ArbReq_rlast(ArbReq_rlast),
    .ArbReq_rdata(ArbReq_rdata),
    .ArbBus_arvalid(ArbBus_arvalid), .ArbBus_araddr(ArbBus_araddr), .ArbBus_arlen(ArbBus_arlen),
    .ArbBus_aruserid(ArbBus_aruserid), .ArbBus_aruserap(ArbBus_aruserap),
    .BusArb_arready(BusArb_arready), .BusArb_rvalid(BusArb_rvalid), .BusArb_rlast(BusArb_rlast),
    .BusArb_rid(BusArb_rid), .BusArb_rdata(BusArb_rdata),
    .arb_busy(arb_busy), .arb_grant(arb_grant), .arb_err_len(arb_err_len)
  );

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    int exp_g;
    int len;
    int nb;
    int aoff;
    bit foreign;
    int bp;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [ID_W-1:0]   id;
    logic              ap;
  } ar_t;

  typedef struct {
    logic [NUM_REQ-1:0] vld;
    logic [NUM_REQ-1:0] last;
    logic [DATA_W-1:0]  data;
  } r_t;

  ar_t  ar_q[$];
  r_t   r_q[$];
  ar_t  ar_e;
  r_t   r_e;
  int   n_vec = 0;
  int   n_err = 0;
  logic err_exp;
  vec_t vt[13];

  function automatic logic [ID_W-1:0] id_of(input int r);
    case (r)
      0:       return 4'hC;
      1:       return 4'h9;
      2:       return 4'h5;
      default: return 4'h3;
    endcase
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int g);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm, input logic [63:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: observed %0h (t=%0t)", nm, act, $time);
  endtask

  // Scoreboard side: every bus handshake and every routed beat must match a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (ArbBus_arvalid && BusArb_arready) begin
        if (ar_q.size() == 0) fail("ar_unexpected", ArbBus_araddr);
        else begin
          ar_e = ar_q.pop_front();
          chk("ar_addr", ArbBus_araddr, ar_e.addr);
          chk("ar_len", ArbBus_arlen, ar_e.len);
          chk("ar_id", ArbBus_aruserid, ar_e.id);
          chk("ar_ap", ArbBus_aruserap, ar_e.ap);
        end
      end
      if (|ArbReq_rvalid) begin
        if (r_q.size() == 0) fail("rvalid_unexpected", ArbReq_rvalid);
        else begin
          r_e = r_q.pop_front();
          chk("r_valid", ArbReq_rvalid, r_e.vld);
          chk("r_last", ArbReq_rlast, r_e.last);
          chk("r_data", ArbReq_rdata, r_e.data);
        end
      end else if (|ArbReq_rlast) begin
        fail("rlast_without_rvalid", ArbReq_rlast);
      end
    end
  end

  task automatic set_reqs(input logic [NUM_REQ-1:0] mask, input int len, input int aoff);
    for (int r = 0; r < NUM_REQ; r++) begin
      ReqArb_araddr[r*ADDR_W +: ADDR_W]  = ADDR_W'(aoff + (r << 8));
      ReqArb_arlen[r*LEN_W +: LEN_W]     = LEN_W'(len);
      ReqArb_aruserid[r*ID_W +: ID_W]    = id_of(r);
      ReqArb_aruserap[r]                 = 1'(r % 2);
    end
    ReqArb_arvalid = mask;
  endtask

  function automatic ar_t exp_ar(input int g, input int len, input int aoff);
    ar_t e;
    e.addr = ADDR_W'(aoff + (g << 8));
    e.len  = LEN_W'(len);
    e.id   = id_of(g);
    e.ap   = 1'(g % 2);
    return e;
  endfunction

  task automatic beat(input logic [ID_W-1:0] rid, input bit last, input int g, input bit expect_out);
    r_t r;
    BusArb_rvalid = 1'b1;
    BusArb_rid    = rid;
    BusArb_rlast  = last;
    BusArb_rdata  = $urandom;
    if (expect_out) begin
      r.vld  = onehot(g);
      r.last = last ? onehot(g) : '0;
      r.data = BusArb_rdata;
      r_q.push_back(r);
    end
    @(posedge clk); #1;
  endtask

  // Waits for the grant pulse, then handles an address phase with bp cycles of back-pressure.
  task automatic addr_phase(input int g, input int bp, input ar_t e);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (ArbReq_arready == '0 && t < 20);
    if (ArbReq_arready == '0) fail("arready_timeout", ArbReq_arready);
    else chk("arready", ArbReq_arready, onehot(g));
    chk("grant", arb_grant, g);
    chk("arvalid_first", ArbBus_arvalid, 1);
    chk("busy_addr", arb_busy, 1);
    if (bp == 0) begin
      @(posedge clk); #1;
      ReqArb_arvalid[g] = 1'b0;
    end else begin
      for (int i = 1; i < bp; i++) begin
        @(posedge clk); #1;
        if (i == 1) ReqArb_arvalid[g] = 1'b0;
        @(negedge clk);
        if (i == 1) chk("arready_one_cycle", ArbReq_arready, 0);
        chk("bp_arvalid", ArbBus_arvalid, 1);
        chk("bp_addr", ArbBus_araddr, e.addr);
        chk("bp_len", ArbBus_arlen, e.len);
        chk("bp_id", ArbBus_aruserid, e.id);
      end
      @(posedge clk); #1;
      ReqArb_arvalid[g] = 1'b0;
      BusArb_arready    = 1'b1;
      @(negedge clk);
      chk("bp_busy", arb_busy, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic txn(input vec_t v);
    ar_t e;
    set_reqs(v.mask, v.len, v.aoff);
    BusArb_arready = (v.bp == 0);
    e = exp_ar(v.exp_g, v.len, v.aoff);
    ar_q.push_back(e);
    addr_phase(v.exp_g, v.bp, e);
    for (int k = 0; k < v.nb; k++) begin
      if (v.foreign && k > 0) beat(id_of(v.exp_g) ^ 4'h6, 1'b1, v.exp_g, 1'b0);
      beat(id_of(v.exp_g), k == v.nb - 1, v.exp_g, 1'b1);
    end
    BusArb_rvalid  = 1'b0;
    BusArb_rlast   = 1'b0;
    ReqArb_arvalid = '0;
    if (v.nb != v.len + 1) err_exp = 1'b1;
    @(negedge clk);
    chk("busy_idle", arb_busy, 0);
    chk("arvalid_idle", ArbBus_arvalid, 0);
    chk("err_len", arb_err_len, err_exp);
    chk("grant_hold", arb_grant, v.exp_g);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    ar_t  e;
    // mask, grant, len, beats, addr offset, foreign, back-pressure
    vt[0]  = '{4'b1111, 0, 0, 1, 'h01000, 0, 0};
    vt[1]  = '{4'b1111, 1, 0, 1, 'h02000, 0, 0};
    vt[2]  = '{4'b1111, 2, 0, 1, 'h03000, 0, 0};
    vt[3]  = '{4'b1111, 3, 0, 1, 'h04000, 0, 0};
    vt[4]  = '{4'b1111, 0, 0, 1, 'h05000, 0, 0};
    vt[5]  = '{4'b0010, 1, 3, 4, 'h00000, 0, 0};
    vt[6]  = '{4'b0101, 2, 1, 2, 'h06000, 1, 0};
    vt[7]  = '{4'b0101, 0, 0, 1, 'h07000, 0, 0};
    vt[8]  = '{4'b1000, 3, 1, 2, 'h08000, 0, 0};
    vt[9]  = '{4'b1001, 0, 0, 1, 'h09000, 0, 0};
    vt[10] = '{4'b0011, 1, 2, 3, 'h0A000, 0, 7};
    vt[11] = '{4'b1001, 3, 3, 2, 'h0B000, 0, 0};
    vt[12] = '{4'b0110, 1, 0, 1, 'h0C000, 0, 0};

    rst = 1'b1;
    err_exp = 1'b0;
    ReqArb_arvalid = '0; ReqArb_araddr = '0; ReqArb_arlen = '0;
    ReqArb_aruserid = '0; ReqArb_aruserap = '0;
    BusArb_arready = 1'b0; BusArb_rvalid = 1'b0; BusArb_rlast = 1'b0;
    BusArb_rid = '0; BusArb_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", arb_busy, 0);
    chk("rst_arvalid", ArbBus_arvalid, 0);
    chk("rst_arready", ArbReq_arready, 0);
    chk("rst_err", arb_err_len, 0);
    chk("rst_grant", arb_grant, 0);
    chk("rst_addr", ArbBus_araddr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) txn(vt[i]);

    // Reset one beat into a 4-beat burst from requester 2; leftover beats must vanish.
    set_reqs(4'b0100, 3, 'h20000);
    BusArb_arready = 1'b1;
    e = exp_ar(2, 3, 'h20000);
    ar_q.push_back(e);
    addr_phase(2, 0, e);
    beat(id_of(2), 1'b0, 2, 1'b1);
    rst = 1'b1;
    BusArb_rvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", arb_busy, 0);
    chk("rstmid_arvalid", ArbBus_arvalid, 0);
    chk("rstmid_err", arb_err_len, 0);
    chk("rstmid_grant", arb_grant, 0);
    @(posedge clk); #1;
    for (int k = 1; k < 4; k++) beat(id_of(2), k == 3, 2, 1'b0);
    BusArb_rvalid = 1'b0;
    BusArb_rlast  = 1'b0;
    @(posedge clk); #1;
    v = '{4'b1111, 0, 0, 1, 'h30000, 0, 0};
    txn(v);

    chk("ar_q_drained", ar_q.size(), 0);
    chk("r_q_drained", r_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
